// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the memory-mapped UART transmitter.
//   - Register word offsets (addr[3:2]) inside the 16-byte window.
//   - STATUS register bit positions.
//   - Transmit FSM state encoding.
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_DIVISOR = 2'd2;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;  // bits [7:4] hold the FIFO count

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: the core's data-memory port as seen by a memory-mapped
// peripheral.
//   memwrite  : store strobe (core -> peripheral)
//   addr      : byte address, the core's aluout (core -> peripheral)
//   writedata : store data (core -> peripheral)
//   sel       : address falls in the peripheral window (peripheral -> core)
//   rdata     : combinational read data, 0 when sel=0 (peripheral -> core)
interface mmio_uart_tx_if;
  import uart_pkg::*;

  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        sel;
  logic [31:0] rdata;

  modport master (output memwrite, addr, writedata, input sel, rdata);
  modport slave  (input memwrite, addr, writedata, output sel, rdata);

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a combinational head output.
//   clk, reset : clock, asynchronous active-high reset (empties the FIFO)
//   push, din  : write strobe and data; ignored while full
//   pop, dout  : read strobe and head data; ignored while empty
//   full, empty, count : occupancy flags and entry count (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok, pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  // The FSM loads the head on the same edge it pops, so the head is read
  // combinationally from the storage array.
  assign dout    = mem[rd_ptr_reg];

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the core's data port.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of mmio_uart_tx_if (memwrite/addr/writedata in,
//                sel/rdata out); reads are combinational, the core never stalls
//   txd        : registered serial output, idles high
//   irq_empty  : FIFO empty and transmitter idle
// Window at BASE_ADDR (16-byte aligned): 0x0 TXDATA (write pushes a byte),
// 0x4 STATUS, 0x8 DIVISOR (clk cycles per bit, 0 behaves as 1), 0xC reserved.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_FF00,
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic           clk,
  input  logic           reset,
  mmio_uart_tx_if.slave  bus,
  output logic           txd,
  output logic           irq_empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [1:0]    offset;
  logic          wr_txdata, wr_status, wr_divisor;
  logic [15:0]   div_reg, div_eff, reload;
  logic          ovf_reg;
  logic [31:0]   rdata_next;
  logic          unused_bits;

  tx_state_t     state_reg, state_next;
  logic [15:0]   baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          pop;

  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  // Address decode and write strobes.
  assign bus.sel     = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign offset      = bus.addr[3:2];
  assign wr_txdata   = bus.memwrite && bus.sel && (offset == OFF_TXDATA);
  assign wr_status   = bus.memwrite && bus.sel && (offset == OFF_STATUS);
  assign wr_divisor  = bus.memwrite && bus.sel && (offset == OFF_DIVISOR);
  assign unused_bits = ^{bus.addr[1:0], bus.writedata[31:16]};

  assign div_eff = (div_reg == 16'd0) ? 16'd1 : div_reg;
  assign reload  = div_eff - 16'd1;

  // The FIFO itself drops pushes while full, so the push strobe is raw.
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .din   (bus.writedata[7:0]),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= DEFAULT_DIV;
      ovf_reg <= 1'b0;
    end else begin
      if (wr_divisor) div_reg <= bus.writedata[15:0];
      if (wr_status && bus.writedata[ST_OVF]) ovf_reg <= 1'b0;
      else if (wr_txdata && fifo_full)        ovf_reg <= 1'b1;
    end
  end

  // Read mux.
  always_comb begin
    rdata_next = '0;
    if (bus.sel) begin
      case (offset)
        OFF_STATUS: begin
          rdata_next[ST_FULL]                 = fifo_full;
          rdata_next[ST_EMPTY]                = fifo_empty;
          rdata_next[ST_BUSY]                 = (state_reg != IDLE);
          rdata_next[ST_OVF]                  = ovf_reg;
          rdata_next[ST_COUNT_LSB +: 4]       = 4'(fifo_count);
        end
        OFF_DIVISOR: rdata_next[15:0] = div_reg;
        default:     rdata_next = '0;
      endcase
    end
  end
  assign bus.rdata = rdata_next;

  // Transmit FSM: state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
    end
  end

  // Transmit FSM: next state. The bit currently on the line is already out
  // of shift_reg, so each bit boundary drives shift_reg[0] and shifts.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;
    if (state_reg == IDLE) begin
      txd_next = 1'b1;
      if (!fifo_empty) begin
        pop        = 1'b1;
        shift_next = fifo_head;
        state_next = START;
        baud_next  = reload;
        txd_next   = 1'b0;
      end
    end else if (baud_reg != 16'd0) begin
      baud_next = baud_reg - 16'd1;
    end else begin
      // Bit boundary: DIVISOR is sampled here, so a mid-bit write only
      // affects the following bits.
      baud_next = reload;
      case (state_reg)
        START: begin
          state_next = DATA;
          bit_next   = 3'd0;
          txd_next   = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
        DATA: begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_next   = bit_reg + 3'd1;
            txd_next   = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end
        STOP: begin
          state_next = IDLE;
          txd_next   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign txd       = txd_reg;
  assign irq_empty = fifo_empty && (state_reg == IDLE);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus for mmio_uart_tx. Expected serial frames
// (byte, per-bit lengths, idle gap before the start bit) are queued when the
// byte is written; a monitor process decodes txd and compares against the
// queue. Register reads are compared against hand-computed constants.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_DIV = BASE + 32'd8;
  localparam logic [31:0] A_RSV = BASE + 32'd12;

  typedef struct {
    logic [7:0]      data;
    logic [9:0][7:0] lens;   // index 0 start, 1..8 data LSB first, 9 stop
    int              gap;    // idle samples before start, -1 = don't care
    int              nbits;  // bits to check (fewer when reset aborts)
  } exp_frame_t;

  logic clk, reset, txd, irq_empty;
  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .DEPTH       (4),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .txd       (txd),
    .irq_empty (irq_empty)
  );

  exp_frame_t expq[$];
  int  errors = 0;
  int  checks = 0;
  logic mon_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [9:0][7:0] uni(input int d);
    logic [9:0][7:0] l;
    for (int i = 0; i < 10; i++) l[i] = 8'(d);
    return l;
  endfunction

  task automatic push_exp(input logic [7:0] d, input logic [9:0][7:0] l, input int gap, input int nbits);
    exp_frame_t e;
    e.data = d; e.lens = l; e.gap = gap; e.nbits = nbits;
    expq.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    $display("wr   addr=%08h data=%08h", a, d);
    bus.memwrite  = 1'b1;
    bus.addr      = a;
    bus.writedata = d;
    @(negedge clk);
    bus.memwrite  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.addr = a;
    #1;
    $display("rd   addr=%08h data=%08h", a, bus.rdata);
    chk(name, bus.rdata, exp);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while ((expq.size() != 0 || mon_busy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain", {31'd0, (expq.size() == 0 && !mon_busy)}, 32'd1);
    repeat (5) @(negedge clk);
  endtask

  // Monitor: decodes frames on txd at every negedge.
  initial begin : monitor
    exp_frame_t  e;
    logic        prev;
    logic        ok;
    logic        bad_lvl;
    logic [9:0]  pat;
    int          idle_cnt;
    int          n;
    prev = 1'b1;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
        idle_cnt = 0;
      end else if (prev && !txd) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: start bit at %0t, required none", $time);
          prev = 1'b0;
        end else begin
          e = expq.pop_front();
          mon_busy = 1'b1;
          if (e.gap >= 0) chk("frame_gap", 32'(idle_cnt), 32'(e.gap));
          pat = {1'b1, e.data, 1'b0};
          for (int i = 0; i < e.nbits; i++) begin
            ok = 1'b1;
            bad_lvl = pat[i];
            for (int k = 0; k < int'(e.lens[i]); k++) begin
              if (i != 0 || k != 0) @(negedge clk);
              if (txd !== pat[i] && ok) begin
                ok = 1'b0;
                bad_lvl = txd;
              end
            end
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame_bit: byte %02h bit %0d got %0b required %0b for %0d cycles",
                       e.data, i, bad_lvl, pat[i], int'(e.lens[i]));
            end
          end
          if (e.nbits < 10) begin
            for (n = 0; n < 200 && !reset; n++) @(negedge clk);
            chk("abort_reset_seen", {31'd0, reset}, 32'd1);
          end else begin
            $display("frame byte=%02h checked", e.data);
          end
          prev = txd;
          idle_cnt = 0;
          mon_busy = 1'b0;
        end
      end else begin
        if (txd) idle_cnt++;
        prev = txd;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [9:0][7:0] l;
    int bad;
    bus.memwrite  = 1'b0;
    bus.addr      = 32'd0;
    bus.writedata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state.
    rd_chk("rst_status", A_ST, 32'h0000_0002);
    rd_chk("rst_divisor", A_DIV, 32'd434);
    chk("rst_sel", {31'd0, bus.sel}, 32'd1);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_irq", {31'd0, irq_empty}, 32'd1);

    // DIVISOR upper bits read as zero, addr[1:0] ignored.
    wr(A_DIV, 32'hFFFF_0007);
    rd_chk("div_upper", A_DIV, 32'h0000_0007);
    rd_chk("div_lowbits_ignored", A_DIV + 32'd3, 32'h0000_0007);

    // Single frame, DIVISOR=4.
    wr(A_DIV, 32'd4);
    push_exp(8'h55, uni(4), -1, 10);
    wr(A_TX, 32'h55);
    rd_chk("queued_status", A_ST, 32'h0000_0010);
    chk("txd_before_pop", {31'd0, txd}, 32'd1);
    @(negedge clk);
    chk("txd_start", {31'd0, txd}, 32'd0);
    rd_chk("busy_status", A_ST, 32'h0000_0006);
    chk("irq_busy", {31'd0, irq_empty}, 32'd0);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      #1;
      if (bus.rdata[2] !== 1'b1) bad++;
    end
    chk("busy_whole_frame", 32'(bad), 32'd0);
    @(negedge clk);
    rd_chk("after_frame_status", A_ST, 32'h0000_0002);
    chk("after_frame_irq", {31'd0, irq_empty}, 32'd1);
    wait_drain(100);

    // Five back-to-back writes, DIVISOR=2: fills FIFO, no overflow.
    wr(A_DIV, 32'd2);
    push_exp(8'h01, uni(2), -1, 10);
    for (int b = 2; b <= 5; b++) push_exp(8'(b), uni(2), 1, 10);
    for (int b = 1; b <= 5; b++) wr(A_TX, 32'(b));
    rd_chk("five_full", A_ST, 32'h0000_0045);
    wait_drain(400);

    // Six back-to-back writes: the sixth is dropped and sets overflow.
    push_exp(8'h11, uni(2), -1, 10);
    for (int b = 2; b <= 5; b++) push_exp(8'(8'h10 + b), uni(2), 1, 10);
    for (int b = 1; b <= 6; b++) wr(A_TX, 32'(8'h10 + b));
    rd_chk("six_overflow", A_ST, 32'h0000_004D);
    wr(A_ST, 32'h8);
    rd_chk("ovf_cleared", A_ST, 32'h0000_0045);
    wait_drain(400);

    // DIVISOR 3 -> 5 written during data bit 3.
    wr(A_DIV, 32'd3);
    for (int i = 0; i < 5; i++) l[i] = 8'd3;
    for (int i = 5; i < 10; i++) l[i] = 8'd5;
    push_exp(8'h96, l, -1, 10);
    wr(A_TX, 32'h96);
    repeat (13) @(negedge clk);
    wr(A_DIV, 32'd5);
    wait_drain(200);

    // DIVISOR=0 behaves as one cycle per bit.
    wr(A_DIV, 32'd0);
    rd_chk("div_zero_read", A_DIV, 32'd0);
    push_exp(8'h3C, uni(1), -1, 10);
    wr(A_TX, 32'h3C);
    wait_drain(100);

    // Out-of-window write and reserved offset.
    bus.memwrite  = 1'b1;
    bus.addr      = 32'h0000_0040;
    bus.writedata = 32'hAB;
    #1;
    $display("wr   addr=%08h data=%08h (outside window)", bus.addr, bus.writedata);
    chk("oow_sel", {31'd0, bus.sel}, 32'd0);
    chk("oow_rdata", bus.rdata, 32'd0);
    @(negedge clk);
    bus.memwrite = 1'b0;
    rd_chk("oow_status", A_ST, 32'h0000_0002);
    rd_chk("rsv_read", A_RSV, 32'd0);
    rd_chk("txdata_read", A_TX, 32'd0);

    // Reset during data bit 5 with two bytes queued.
    wr(A_DIV, 32'd4);
    push_exp(8'hA5, uni(4), -1, 6);
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'hB1);
    wr(A_TX, 32'hC2);
    rd_chk("two_queued", A_ST, 32'h0000_0024);
    repeat (24) @(negedge clk);
    reset = 1'b1;
    #1;
    $display("reset asserted mid-frame");
    chk("reset_txd", {31'd0, txd}, 32'd1);
    rd_chk("reset_status", A_ST, 32'h0000_0002);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd_chk("reset_divisor", A_DIV, 32'd434);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    chk("no_frame_after_reset", 32'(bad), 32'd0);
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
